// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings, FSM states,
// misalignment detection and the read-modify-write lane merge.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_HOLD
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == 2'b01) && off[0]) ||
               ((funct3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    // Replace only the addressed byte/halfword lanes of the fetched word.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] off, input logic [2:0] funct3);
        logic [31:0] res;
        res = word;
        if (funct3[1:0] == 2'b00)
            res[{off, 3'b000} +: 8] = data[7:0];
        else if (funct3[1:0] == 2'b01)
            res[{off[1], 4'b0000} +: 16] = data[15:0];
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-result lane select and sign/zero extension from a 32-bit read word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data = {24'h000000, byte_v};
            F3_LH:   data = {{16{half_v[15]}}, half_v};
            F3_LHU:  data = {16'h0000, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: word stores direct, sub-word stores via read-modify-write, loads aligned next cycle.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse misalign_o instead of aligning.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_valid_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [2:0]  x_funct3_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] x_store_data_i,
    output logic        stall_o,
    output logic        x_dm_wen_o,
    output logic [31:0] x_dm_addr_o,
    output logic [31:0] x_dm_din_o,
    input  logic [31:0] m_dm_dout_i,
    output logic [31:0] m_load_data_o,
    output logic        m_load_valid_o,
    output logic        misalign_o
);

    state_t      state, state_next;
    logic [31:0] addr_q, data_q, eff_addr, aligned;
    logic [2:0]  funct3_q, ld_funct3_q;
    logic [1:0]  ld_off_q;
    logic        load_valid_q, is_load, is_store, mis, st_go, ld_go;

    assign is_store = x_valid_i & x_store_i;
    assign is_load  = x_valid_i & x_load_i & ~x_store_i;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign eff_addr   = x_addr_i;
    assign mis        = (is_load | is_store) & is_misaligned(x_funct3_i, x_addr_i[1:0]);
    assign misalign_o = misalign_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) misalign_q <= 1'b0;
        else          misalign_q <= (state == ST_IDLE) & mis;
    end
`else
    always_comb begin
        eff_addr = x_addr_i;
        if (x_funct3_i[1:0] == 2'b01)
            eff_addr[0] = 1'b0;
        else if (x_funct3_i[1:0] == 2'b10)
            eff_addr[1:0] = 2'b00;
    end
    assign mis        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign st_go = is_store & ~mis;
    assign ld_go = is_load & ~mis;

    always_comb begin
        state_next  = state;
        x_dm_wen_o  = 1'b0;
        stall_o     = 1'b0;
        x_dm_din_o  = data_q;
        x_dm_addr_o = {addr_q[31:2], 2'b00};
        case (state)
            ST_IDLE: begin
                x_dm_addr_o = {eff_addr[31:2], 2'b00};
                x_dm_din_o  = x_store_data_i;
                if (st_go) begin
                    stall_o = 1'b1;
                    if (x_funct3_i[1]) begin
                        x_dm_wen_o = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                x_dm_din_o = store_merge(m_dm_dout_i, data_q, addr_q[1:0], funct3_q);
                x_dm_wen_o = 1'b1;
                stall_o    = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            funct3_q     <= '0;
            ld_funct3_q  <= '0;
            ld_off_q     <= '0;
            load_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            load_valid_q <= (state == ST_IDLE) & ld_go;
            if (state == ST_IDLE && st_go) begin
                addr_q   <= eff_addr;
                data_q   <= x_store_data_i;
                funct3_q <= x_funct3_i;
            end
            if (state == ST_IDLE && ld_go) begin
                ld_funct3_q <= x_funct3_i;
                ld_off_q    <= eff_addr[1:0];
            end
        end
    end

    lsu_load_align u_align (
        .word   (m_dm_dout_i),
        .off    (ld_off_q),
        .funct3 (ld_funct3_q),
        .data   (aligned)
    );

    assign m_load_valid_o = load_valid_q;
    assign m_load_data_o  = load_valid_q ? aligned : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a one-cycle-latency word memory model.
module tb_lsu;

    logic        clk, rst_n;
    logic        x_valid, x_load, x_store;
    logic [2:0]  x_funct3;
    logic [31:0] x_addr, x_store_data;
    logic        stall, dm_wen, load_valid, misalign;
    logic [31:0] dm_addr, dm_din, dm_dout, load_data;

    logic [31:0] mem [0:16383];
    logic        wen_q;
    logic [31:0] din_q;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    lsu dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .x_valid_i      (x_valid),
        .x_load_i       (x_load),
        .x_store_i      (x_store),
        .x_funct3_i     (x_funct3),
        .x_addr_i       (x_addr),
        .x_store_data_i (x_store_data),
        .stall_o        (stall),
        .x_dm_wen_o     (dm_wen),
        .x_dm_addr_o    (dm_addr),
        .x_dm_din_o     (dm_din),
        .m_dm_dout_i    (dm_dout),
        .m_load_data_o  (load_data),
        .m_load_valid_o (load_valid),
        .misalign_o     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data one cycle after the address; write lands at the address of the cycle after wen.
    always @(posedge clk) begin
        if (wen_q) mem[dm_addr[15:2]] <= din_q;
        dout_update();
        wen_q <= dm_wen;
        din_q <= dm_din;
    end

    task automatic dout_update();
        dm_dout <= mem[dm_addr[15:2]];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        x_valid = 1'b0; x_load = 1'b0; x_store = 1'b0;
        tick();
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_din, input logic both);
        x_valid = 1'b1; x_store = 1'b1; x_load = both;
        x_funct3 = f3; x_addr = addr; x_store_data = data;
        #1;
        check("st_c0_stall", {31'd0, stall}, 32'd1);
        check("st_c0_addr", dm_addr, {addr[31:2], 2'b00});
        if (f3 == 3'b010) begin
            check("sw_c0_wen", {31'd0, dm_wen}, 32'd1);
            check("sw_c0_din", dm_din, data);
        end else begin
            check("sub_c0_wen", {31'd0, dm_wen}, 32'd0);
            tick();
            check("rd_wen", {31'd0, dm_wen}, 32'd1);
            check("rd_stall", {31'd0, stall}, 32'd1);
            check("rd_din", dm_din, exp_din);
        end
        tick();
        check("hold_wen", {31'd0, dm_wen}, 32'd0);
        check("hold_stall", {31'd0, stall}, 32'd0);
        check("hold_addr", dm_addr, {addr[31:2], 2'b00});
        tick();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        x_valid = 1'b1; x_load = 1'b1; x_store = 1'b0;
        x_funct3 = f3; x_addr = addr;
        #1;
        check("ld_stall", {31'd0, stall}, 32'd0);
        check("ld_wen", {31'd0, dm_wen}, 32'd0);
        tick();
        x_valid = 1'b0; x_load = 1'b0;
        #1;
        check("ld_valid", {31'd0, load_valid}, 32'd1);
        check("ld_data", load_data, exp);
        check("ld_misalign", {31'd0, misalign}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; wen_q = 1'b0; din_q = '0;
        x_valid = 1'b0; x_load = 1'b0; x_store = 1'b0;
        x_funct3 = '0; x_addr = '0; x_store_data = '0;
        #3;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wen", {31'd0, dm_wen}, 32'd0);
        check("rst_lvalid", {31'd0, load_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_ldata", load_data, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // SW then readback
        store(3'b010, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0);
        load(3'b010, 32'h1000, 32'hDEADBEEF);

        // SB read-modify-write
        store(3'b010, 32'h2000, 32'h11223344, 32'h0, 1'b0);
        store(3'b000, 32'h2002, 32'h000000AA, 32'h11AA3344, 1'b0);
        load(3'b010, 32'h2000, 32'h11AA3344);

        // load lane select / extension
        store(3'b010, 32'h3000, 32'h8000FF7F, 32'h0, 1'b0);
        load(3'b000, 32'h3000, 32'h0000007F);
        load(3'b000, 32'h3001, 32'hFFFFFFFF);
        load(3'b101, 32'h3002, 32'h00008000);
        load(3'b001, 32'h3002, 32'hFFFF8000);
        load(3'b100, 32'h3001, 32'h000000FF);
        load(3'b001, 32'h3000, 32'hFFFFFF7F);

        // load and store both high acts as a store
        store(3'b010, 32'h3800, 32'h0BADF00D, 32'h0, 1'b1);
        load(3'b010, 32'h3800, 32'h0BADF00D);

        // misaligned word load
        store(3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        x_valid = 1'b1; x_load = 1'b1; x_store = 1'b0; x_funct3 = 3'b010; x_addr = 32'h4002;
        #1;
        check("mis_c0_stall", {31'd0, stall}, 32'd0);
        check("mis_c0_wen", {31'd0, dm_wen}, 32'd0);
        check("mis_c0_pulse", {31'd0, misalign}, 32'd0);
        tick();
        x_valid = 1'b0; x_load = 1'b0;
        #1;
        check("mis_c1_pulse", {31'd0, misalign}, 32'd1);
        check("mis_c1_lvalid", {31'd0, load_valid}, 32'd0);
        tick();
        check("mis_c2_pulse", {31'd0, misalign}, 32'd0);
`else
        x_valid = 1'b1; x_load = 1'b1; x_store = 1'b0; x_funct3 = 3'b010; x_addr = 32'h4002;
        #1;
        check("mis_addr", dm_addr, 32'h00004000);
        tick();
        x_valid = 1'b0; x_load = 1'b0;
        #1;
        check("mis_lvalid", {31'd0, load_valid}, 32'd1);
        check("mis_data", load_data, 32'hCAFEF00D);
        check("mis_pulse", {31'd0, misalign}, 32'd0);
        tick();
`endif

        // SH followed immediately by LW, no bubble
        store(3'b010, 32'h5000, 32'h12345678, 32'h0, 1'b0);
        store(3'b001, 32'h5000, 32'h0000BEEF, 32'h1234BEEF, 1'b0);
        load(3'b010, 32'h5000, 32'h1234BEEF);

        // idle request: no valid result
        idle();
        check("idle_lvalid", {31'd0, load_valid}, 32'd0);
        check("idle_stall", {31'd0, stall}, 32'd0);

        // reset during RD aborts the store
        store(3'b010, 32'h6000, 32'h55667788, 32'h0, 1'b0);
        x_valid = 1'b1; x_store = 1'b1; x_load = 1'b0;
        x_funct3 = 3'b000; x_addr = 32'h6001; x_store_data = 32'h00000099;
        #1;
        check("abort_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        check("abort_rd_wen", {31'd0, dm_wen}, 32'd1);
        check("abort_rd_din", dm_din, 32'h55669988);
        rst_n = 1'b0;
        x_valid = 1'b0; x_store = 1'b0;
        #1;
        check("abort_wen", {31'd0, dm_wen}, 32'd0);
        check("abort_stall", {31'd0, stall}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_wen", {31'd0, dm_wen}, 32'd0);
        end
        check("abort_mem", mem[32'h6000 >> 2], 32'h55667788);
        load(3'b010, 32'h6000, 32'h55667788);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
